// File: rtl/range_xform_pkg.sv
// Shared constants and helpers for the bit-range transform FIFO.
package range_xform_pkg;

  // Transform select encodings
  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_REV    = 2'd1;
  localparam logic [1:0] MODE_ANDREV = 2'd2;
  localparam logic [1:0] MODE_INC    = 2'd3;

  // Widest word bit_rev can handle
  localparam int MAX_W = 32;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  // Bits are shifted out of v's LSB into r's LSB, so after w steps the
  // first bit taken (v[0]) has reached r[w-1].
  function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] v_s;
    r   = {MAX_W{1'b0}};
    v_s = v;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        r   = {r[MAX_W-2:0], v_s[0]};
        v_s = v_s >> 1;
      end else begin
        r   = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/range_fifo.sv
// Generic synchronous FIFO with a registered show-ahead head.
// rdata always holds the current head entry and keeps its last value when empty.
module range_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              push_s, pop_s, head_from_write_s;

  // Next-state: pointers, occupancy, storage and the head register
  always_comb begin
    mem_d             = mem_q;
    push_s            = push && (count_q != CW'(DEPTH));
    pop_s             = pop && (count_q != {CW{1'b0}});
    // The new word becomes the head when nothing older survives this edge
    head_from_write_s = (count_q == {CW{1'b0}}) || ((count_q == CW'(1)) && pop_s);

    wptr_d = push_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + AW'(1)) : rptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_s) begin
      mem_d[wptr_q] = wdata;
    end else begin
      mem_d = mem_q;
    end

    if (count_d == {CW{1'b0}}) begin
      rdata_d = rdata_q;
    end else if (push_s && head_from_write_s) begin
      rdata_d = wdata;
    end else begin
      rdata_d = mem_q[rptr_d];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: {DATA_W{1'b0}}};
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});

endmodule

// File: rtl/range_xform_fifo.sv
// Bit-range transform unit: words declared on [LO+W-1:LO] are transformed,
// one declared bit is extracted, and {result, bit, sel_err} is queued.
module range_xform_fifo
  import range_xform_pkg::*;
#(
  parameter int W     = 4,
  parameter int LO    = 1,
  parameter int DEPTH = 4,
  parameter int SW    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LO+W-1:LO]           in_data,
  input  logic [1:0]                 in_mode,
  input  logic [SW-1:0]              in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LO+W-1:LO]           out_data,
  output logic                       out_bit,
  output logic                       out_sel_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  logic [W-1:0]     d_s, rev_s, r_s, sh_s;
  logic [MAX_W-1:0] rev_full_s;
  logic [SW-1:0]    off_s;
  logic             bit_s, err_s;
  logic             push_s, pop_s, full_s, empty_s;
  logic [W+1:0]     rdata_s;

  // Transform and bit extract on the incoming word (declared index i is physical i-LO)
  always_comb begin
    d_s        = in_data;
    rev_full_s = bit_rev(MAX_W'(d_s), W);
    rev_s      = rev_full_s[W-1:0];

    case (in_mode)
      MODE_PASS:   r_s = d_s;
      MODE_REV:    r_s = rev_s;
      MODE_ANDREV: r_s = d_s & rev_s;
      MODE_INC:    r_s = d_s + W'(1'b1);
      default:     r_s = d_s;
    endcase

    if ((int'(in_sel) >= LO) && (int'(in_sel) <= LO + W - 1)) begin
      off_s = in_sel - SW'(LO);
      sh_s  = r_s >> off_s;
      bit_s = sh_s[0];
      err_s = 1'b0;
    end else begin
      off_s = {SW{1'b0}};
      sh_s  = r_s;
      bit_s = 1'b0;
      err_s = 1'b1;
    end

    // Acceptance ignores out_ready: a full FIFO takes nothing
    push_s = in_valid && !full_s;
    pop_s  = out_ready && !empty_s;
  end

  range_fifo #(
    .DATA_W (W + 2),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({r_s, bit_s, err_s}),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count)
  );

  assign in_ready    = !full_s;
  assign out_valid   = !empty_s;
  assign out_data    = rdata_s[W+1:2];
  assign out_bit     = rdata_s[1];
  assign out_sel_err = rdata_s[0];

endmodule

// File: tb/tb_range_xform_fifo.sv
// Self-checking bench for range_xform_fifo (W=4, LO=1, DEPTH=4, SW=4).
module tb_range_xform_fifo;

  localparam int W     = 4;
  localparam int LO    = 1;
  localparam int DEPTH = 4;
  localparam int SW    = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = 4'd0;
  logic [1:0]    in_mode = 2'd0;
  logic [SW-1:0] in_sel = 4'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_bit;
  logic          out_sel_err;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;
  logic [W+1:0] sb_q [$];

  range_xform_fifo #(.W(W), .LO(LO), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bit(out_bit), .out_sel_err(out_sel_err), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: expected {result, bit, err} for one pushed word
  function automatic logic [W+1:0] exp_of(input logic [W-1:0] d, input logic [1:0] m,
                                          input logic [SW-1:0] s);
    logic [W-1:0] rv, r, t;
    logic b, e;
    int si;
    rv = '0;
    for (int k = 0; k < W; k++) rv = rv | (((d >> k) & W'(1)) << (W - 1 - k));
    case (m)
      2'd0:    r = d;
      2'd1:    r = rv;
      2'd2:    r = d & rv;
      default: r = d + W'(1);
    endcase
    si = int'(s);
    if (si >= LO && si <= LO + W - 1) begin
      t = r >> (si - LO);
      b = t[0];
      e = 1'b0;
    end else begin
      b = 1'b0;
      e = 1'b1;
    end
    return {r, b, e};
  endfunction

  // Scoreboard: record accepted pushes, compare every pop against the queue head
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %b/%b/%b, queue empty", out_data, out_bit, out_sel_err);
        end else begin
          logic [W+1:0] e;
          e = sb_q.pop_front();
          if ({out_data, out_bit, out_sel_err} !== e) begin
            errors++;
            $display("FAIL pop_data: got %b/%b/%b, expected %b/%b/%b",
                     out_data, out_bit, out_sel_err, e[W+1:2], e[1], e[0]);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(exp_of(in_data, in_mode, in_sel));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Hold a word on the input until it is accepted (bounded)
  task automatic drive_push(input logic [W-1:0] d, input logic [1:0] m, input logic [SW-1:0] s);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_sel = s;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %b never accepted", d);
    end
  endtask

  // Pop until empty (bounded)
  task automatic wait_empty();
    out_ready = 1'b1;
    for (int i = 0; i < 30 && out_valid; i++) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: out_valid=%b, expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({count, out_valid, out_data, out_bit, out_sel_err, in_ready} !== {3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: count=%0d ov=%b od=%b ob=%b err=%b ir=%b", count, out_valid, out_data, out_bit, out_sel_err, in_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_first_rev();
    out_ready = 1'b1;
    drive_push(4'b1100, 2'd1, 4'd4);
    checks++;
    if ({out_valid, out_data, out_bit, out_sel_err, count} !== {1'b1, 4'b0011, 1'b0, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL first_rev: ov=%b od=%b ob=%b err=%b count=%0d, expected 1 0011 0 0 1",
               out_valid, out_data, out_bit, out_sel_err, count);
    end
    wait_empty();
  endtask

  task automatic test_modes();
    out_ready = 1'b1;
    drive_push(4'b1100, 2'd2, 4'd1);
    drive_push(4'b1010, 2'd0, 4'd4);
    drive_push(4'b0010, 2'd3, 4'd2);
    drive_push(4'b1111, 2'd3, 4'd3);
    drive_push(4'b0110, 2'd0, 4'd0);
    drive_push(4'b1001, 2'd1, 4'd5);
    drive_push(4'b0111, 2'd2, 4'd15);
    wait_empty();
    checks++;
    if ({out_bit, out_sel_err} !== 2'b01) begin
      errors++;
      $display("FAIL sel_oob_hold: bit=%b err=%b, expected 0 1", out_bit, out_sel_err);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    drive_push(4'b0001, 2'd0, 4'd1);
    drive_push(4'b0010, 2'd1, 4'd2);
    drive_push(4'b0100, 2'd3, 4'd3);
    drive_push(4'b1000, 2'd2, 4'd4);
    in_valid = 1'b1; in_data = 4'b1011; in_mode = 2'd0; in_sel = 4'd4;
    step(); step();
    checks++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_hold: count=%0d in_ready=%b, expected 4 0", count, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({count, in_ready} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL first_pop: count=%0d in_ready=%b, expected 3 1", count, in_ready);
    end
    step();
    in_valid = 1'b0;
    wait_empty();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_push(4'b0101, 2'd0, 4'd1);
    drive_push(4'b0011, 2'd1, 4'd2);
    in_valid = 1'b1; in_data = 4'b1110; in_mode = 2'd3; in_sel = 4'd4;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL pushpop_mid: count=%0d, expected 2", count);
    end
    drive_push(4'b1001, 2'd2, 4'd3);
    drive_push(4'b0110, 2'd0, 4'd2);
    in_valid = 1'b1; in_data = 4'b1111; in_mode = 2'd0; in_sel = 4'd1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({count, in_ready} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL pushpop_full: count=%0d in_ready=%b, expected 3 1", count, in_ready);
    end
    wait_empty();
    checks++;
    if (out_data !== 4'b0110) begin
      errors++;
      $display("FAIL hold_last: out_data=%b, expected 0110", out_data);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive_push(4'b1101, 2'd0, 4'd1);
    drive_push(4'b1011, 2'd1, 4'd2);
    drive_push(4'b0111, 2'd3, 4'd3);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_count: count=%0d, expected 3", count);
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 4'b1000; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({count, out_valid, out_data, in_ready} !== {3'd0, 1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: count=%0d ov=%b od=%b ir=%b, expected 0 0 0000 1", count, out_valid, out_data, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_after_reset: out_valid=%b, expected 0", out_valid);
      end
    end
    drive_push(4'b0100, 2'd1, 4'd2);
    wait_empty();
  endtask

  initial begin
    test_reset();
    test_first_rev();
    test_modes();
    test_fill();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/range_xform_fifo.md
Name: range_xform_fifo

Overview:
Parametrised, buffered bit-range transform unit; the sequential successor to the team's fixed-width mixed-range checks. Accepts words declared on an arbitrary offset range [LO+W-1:LO] and applies one of four per-word transforms: pass, bit-reverse, AND-with-reverse, increment. Each also extracts one bit by declared index. Results are queued in a DEPTH-entry FIFO behind a valid/ready handshake, so the simulator's range, reversal and part-select semantics are exercised under back-pressure.

Parameters:
W, 4, data width in bits
LO, 1, low index of the declared data range; data occupies [LO+W-1:LO]
DEPTH, 4, FIFO entries (>=2, power of two)
SW, 4, width of the bit-select index (must hold LO+W-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset: synchronous, active-high
in_valid  input  1  input word present
in_ready  output  1  FIFO can accept a word
in_data  input  W  operand, declared [LO+W-1:LO]
in_mode  input  2  transform select
in_sel  input  SW  declared bit index to extract from the result
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  W  transformed word, declared [LO+W-1:LO]
out_bit  output  1  result bit at in_sel
out_sel_err  output  1  in_sel was outside [LO+W-1:LO]
count  output  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (synchronous, active-high): count=0, out_valid=0, out_data=0, out_bit=0, out_sel_err=0, in_ready=1, read/write pointers=0. Reset mid-stream discards all entries. Any push or pop in the reset cycle is ignored.
- Index mapping: declared index i maps to physical offset i-LO from the LSB. All transforms operate on declared indices.
- Modes, evaluated combinationally at push:
  - 0 PASS: r = in_data.
  - 1 REV: r[LO+k] = in_data[LO+W-1-k], k = 0..W-1.
  - 2 ANDREV: r = in_data & REV(in_data).
  - 3 INC: r = in_data + 1, truncated to W bits; all-ones wraps to 0 and no carry is kept.
- Bit extract: if LO <= in_sel <= LO+W-1, then out_bit = r[in_sel] and err = 0. Otherwise out_bit = 0 and err = 1.
- Stored entry: {r, out_bit, err}.
- Push: in_valid && in_ready at the rising edge. in_ready = (count < DEPTH) and does not depend on out_ready, so a full FIFO accepts nothing even when a pop occurs in the same cycle.
- Pop: out_valid && out_ready at the rising edge.
- out_valid = (count != 0). out_data, out_bit and out_sel_err show the head entry (show-ahead). When out_valid=0 these outputs hold their last value.
- Latency: a word pushed at edge N is visible at the outputs after edge N (1 cycle) when the FIFO was empty. There is no combinational in-to-out path.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Order is strict FIFO.
- Push with in_valid=0, or pop with out_ready=0: no state change.
- in_mode and in_sel are sampled only on a push.

Decomposition:
- Package range_xform_pkg holds:
  - mode localparams MODE_PASS=2'd0, MODE_REV=2'd1, MODE_ANDREV=2'd2, MODE_INC=2'd3;
  - function bit_rev(W).
- One sub-module, range_fifo: a generic synchronous FIFO with parameters DATA_W and DEPTH and ports clk, rst, push, pop, wdata, rdata, full, empty, count. The transform and extract logic stays in the top level.

Test Plan:
- Reset, then push in_data=4'b1100, mode REV, in_sel=4, with out_ready=1 -> one cycle later out_valid=1, out_data=4'b0011, out_bit=0, out_sel_err=0, count=1.
- Push 4'b1100 ANDREV, then 4'b1010 PASS -> out_data=4'b0000, then out_data=4'b1010, in order.
- Push 4'b0010 INC with in_sel=2 -> out_data=4'b0011, out_bit=1. Push 4'b1111 INC -> out_data=4'b0000. Push with in_sel=0 or in_sel=5 -> out_bit=0, out_sel_err=1.
- Fill with out_ready=0: 4 pushes -> count=4 and in_ready=0. A 5th held in_valid is not accepted. Raise out_ready -> the 4 words drain in order, in_ready=1 after the first pop, then the 5th word is accepted.
- At count=2, assert push and pop in the same cycle -> count stays 2, the correct head pops, and the new word lands at the tail. At count=4 with push and pop both asserted -> only the pop occurs and count=3.
- At count=3, assert rst for one cycle alongside in_valid and out_ready -> next cycle count=0, out_valid=0, out_data=0, in_ready=1, and no stale data appears afterward.
